stopwatch_pb_controller: RTL and testbench

- Sequences a stopwatch/counter datapath from two debounced push buttons (START/STOP and LAP/RESET).
- Sits between the debounce circuits and the counter/display datapath; runs on the system crystal clock `clk`.
- Uses the 100 Hz one-cycle enable from the clock generator as its timebase for long-press timing.
- Outputs are level controls (count enable, lap hold) and one-cycle pulses (clear, long press).

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/stopwatch_pb_controller_pb_event_detect.sv | 93 +++++++++
 rtl/stopwatch_pb_controller.sv | 122 ++++++++++++
 tb/tb_stopwatch_pb_controller.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants and FSM state encoding for the stopwatch push-button controller.
package stopwatch_pkg;

  localparam int unsigned STATE_W               = 2;
  localparam int unsigned LONG_PRESS_TICKS_DEF  = 200;
  localparam int unsigned TICK_CNT_W_DEF        = 8;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    LAP   = 2'b10,
    PAUSE = 2'b11
  } state_e;

endpackage

// File: rtl/stopwatch_pb_controller_pb_event_detect.sv
// Push-button event detector: optional 2-flop synchronizer (PB_SYNC_EN), sampled
// level, rise/fall pulses and an optional saturating long-press tick counter.
// A button already held when reset releases is ignored until it is seen released.
module pb_event_detect #(
  parameter bit          LONG_EN    = 1'b0,
  parameter int unsigned LONG_TICKS = 200,
  parameter int unsigned CNT_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_100,
  input  logic pb,
  output logic rise_c,
  output logic fall_c,
  output logic long_c
);

  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LONG_TICKS - 1);

  logic             samp_q, samp_d;
  logic             prev_q, prev_d;
  logic             armed_q, armed_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stage_c;
  logic             pipe_low_c;

`ifdef PB_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // Two-flop synchronizer for an input that may be asynchronous to clk
  always_comb begin
    sync1_d    = pb;
    sync2_d    = sync1_q;
    stage_c    = sync2_q;
    pipe_low_c = ~pb & ~sync1_q & ~sync2_q;
  end

  // Synchronizer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end
`else
  // Input is already synchronous to clk; feed it straight to the sampler
  always_comb begin
    stage_c    = pb;
    pipe_low_c = ~pb;
  end
`endif

  // Sample/edge registers, arming and long-press counter next-state
  always_comb begin
    samp_d  = stage_c;
    prev_d  = samp_q;
    armed_d = armed_q | (pipe_low_c & ~samp_q & ~prev_q);
    cnt_d   = cnt_q;
    if (!samp_q || !armed_q || !LONG_EN) begin
      cnt_d = '0;
    end else if (tick_100 && (cnt_q != CNT_SAT)) begin
      cnt_d = CNT_W'(cnt_q + 1'b1);
    end
  end

  // Event pulses; a fall after a completed long press is swallowed
  always_comb begin
    rise_c = armed_q & samp_q & ~prev_q;
    fall_c = armed_q & ~samp_q & prev_q & (cnt_q != CNT_SAT);
    long_c = LONG_EN & armed_q & samp_q & tick_100 & (cnt_q == CNT_LAST);
  end

  // Detector state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp_q  <= 1'b0;
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      samp_q  <= samp_d;
      prev_q  <= prev_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/stopwatch_pb_controller.sv
// Stopwatch controller: turns START/STOP and LAP/RESET button events into
// counter enable, lap hold, clear and long-press controls.
// Optional macro PB_SYNC_EN adds a 2-flop input synchronizer per button.
module stopwatch_pb_controller
  import stopwatch_pkg::*;
#(
  parameter int unsigned LONG_PRESS_TICKS = LONG_PRESS_TICKS_DEF,
  parameter int unsigned TICK_CNT_W       = TICK_CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_100,
  input  logic       pb_start,
  input  logic       pb_lap,
  output logic       count_en,
  output logic       lap_hold,
  output logic       clear,
  output logic       long_press,
  output logic [1:0] state_o
);

  state_e state_q, state_d;
  logic   count_en_q, count_en_d;
  logic   lap_hold_q, lap_hold_d;
  logic   clear_q, clear_d;
  logic   long_press_q, long_press_d;

  logic start_ev_c;
  logic start_fall_c;
  logic start_long_c;
  logic lap_short_ev_c;
  logic lap_long_ev_c;
  logic lap_rise_c;

  pb_event_detect #(
    .LONG_EN    (1'b0),
    .LONG_TICKS (LONG_PRESS_TICKS),
    .CNT_W      (TICK_CNT_W)
  ) u_start_det (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_100 (tick_100),
    .pb       (pb_start),
    .rise_c   (start_ev_c),
    .fall_c   (start_fall_c),
    .long_c   (start_long_c)
  );

  pb_event_detect #(
    .LONG_EN    (1'b1),
    .LONG_TICKS (LONG_PRESS_TICKS),
    .CNT_W      (TICK_CNT_W)
  ) u_lap_det (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_100 (tick_100),
    .pb       (pb_lap),
    .rise_c   (lap_rise_c),
    .fall_c   (lap_short_ev_c),
    .long_c   (lap_long_ev_c)
  );

  // Next state and output decode; START wins over any same-cycle LAP event
  always_comb begin
    state_d      = state_q;
    clear_d      = 1'b0;
    long_press_d = lap_long_ev_c;
    unique case (state_q)
      IDLE: begin
        if (start_ev_c)         state_d = RUN;
        else if (lap_long_ev_c) clear_d = 1'b1;
      end
      RUN: begin
        if (start_ev_c)          state_d = PAUSE;
        else if (lap_short_ev_c) state_d = LAP;
      end
      LAP: begin
        if (start_ev_c)          state_d = PAUSE;
        else if (lap_short_ev_c) state_d = RUN;
      end
      PAUSE: begin
        if (start_ev_c) begin
          state_d = RUN;
        end else if (lap_long_ev_c) begin
          state_d = IDLE;
          clear_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    count_en_d = (state_d == RUN) || (state_d == LAP);
    lap_hold_d = (state_d == LAP);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      count_en_q   <= 1'b0;
      lap_hold_q   <= 1'b0;
      clear_q      <= 1'b0;
      long_press_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_en_q   <= count_en_d;
      lap_hold_q   <= lap_hold_d;
      clear_q      <= clear_d;
      long_press_q <= long_press_d;
    end
  end

  assign count_en   = count_en_q;
  assign lap_hold   = lap_hold_q;
  assign clear      = clear_q;
  assign long_press = long_press_q;
  assign state_o    = state_q;

  // Unused detector outputs, kept so both instances share one port list
  logic unused_c;
  assign unused_c = start_fall_c ^ start_long_c ^ lap_rise_c;

endmodule

// File: tb/tb_stopwatch_pb_controller.sv
// Directed self-checking bench for stopwatch_pb_controller.
module tb_stopwatch_pb_controller;

`ifdef PB_SYNC_EN
  localparam int D = 3;
`else
  localparam int D = 1;
`endif

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_LAP   = 2'b10;
  localparam logic [1:0] S_PAUSE = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_100;
  logic       pb_start;
  logic       pb_lap;
  logic       count_en;
  logic       lap_hold;
  logic       clear;
  logic       long_press;
  logic [1:0] state_o;

  int n_checks = 0;
  int n_err    = 0;
  int pulse_cnt;

  stopwatch_pb_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick_100   (tick_100),
    .pb_start   (pb_start),
    .pb_lap     (pb_lap),
    .count_en   (count_en),
    .lap_hold   (lap_hold),
    .clear      (clear),
    .long_press (long_press),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Input change was just driven: state holds for D edges, changes on edge D+1
  task automatic expect_tr(input string tag, input logic [1:0] from_s, input logic [1:0] to_s);
    repeat (D) @(negedge clk);
    chk({tag, "_before"}, 32'(state_o), 32'(from_s));
    @(negedge clk);
    chk(tag, 32'(state_o), 32'(to_s));
  endtask

  // Issue n tick_100 pulses one every other clock, counting output pulses seen
  task automatic give_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_100 = 1'b1;
      @(negedge clk);
      pulse_cnt += int'(long_press | clear);
      tick_100 = 1'b0;
      @(negedge clk);
      pulse_cnt += int'(long_press | clear);
    end
  endtask

  task automatic press_start();
    pb_start = 1'b1;
    step(2);
    pb_start = 1'b0;
    step(D + 5);
  endtask

  initial begin
    rst_n    = 1'b0;
    tick_100 = 1'b0;
    pb_start = 1'b0;
    pb_lap   = 1'b0;
    step(3);
    chk("rst_state", 32'(state_o), 32'(S_IDLE));
    chk("rst_count_en", 32'(count_en), 0);
    chk("rst_lap_hold", 32'(lap_hold), 0);
    chk("rst_clear", 32'(clear), 0);
    chk("rst_long", 32'(long_press), 0);
    rst_n = 1'b1;
    step(3);

    // Long LAP in IDLE: clear + long_press, stay IDLE
    pb_lap = 1'b1;
    step(5);
    pulse_cnt = 0;
    give_ticks(199);
    chk("idle_long_early", 32'(pulse_cnt), 0);
    tick_100 = 1'b1;
    @(negedge clk);
    tick_100 = 1'b0;
    chk("idle_long_clear", 32'(clear), 1);
    chk("idle_long_pulse", 32'(long_press), 1);
    chk("idle_long_state", 32'(state_o), 32'(S_IDLE));
    @(negedge clk);
    chk("idle_long_clear_w", 32'(clear), 0);
    chk("idle_long_pulse_w", 32'(long_press), 0);
    pb_lap = 1'b0;
    step(D + 5);

    // START from IDLE, then second press to PAUSE
    pb_start = 1'b1;
    expect_tr("start_run", S_IDLE, S_RUN);
    chk("start_run_en", 32'(count_en), 1);
    pb_start = 1'b0;
    step(D + 5);
    pb_start = 1'b1;
    expect_tr("start_pause", S_RUN, S_PAUSE);
    chk("start_pause_en", 32'(count_en), 0);
    pb_start = 1'b0;
    step(D + 5);
    press_start();
    chk("resume_run", 32'(state_o), 32'(S_RUN));

    // Short LAP in RUN, then again to return
    pb_lap = 1'b1;
    step(3);
    pulse_cnt = 0;
    give_ticks(50);
    chk("short_hold_state", 32'(state_o), 32'(S_RUN));
    chk("short_hold_pulses", 32'(pulse_cnt), 0);
    pb_lap = 1'b0;
    expect_tr("short_lap", S_RUN, S_LAP);
    chk("short_lap_hold", 32'(lap_hold), 1);
    chk("short_lap_en", 32'(count_en), 1);
    step(5);
    pb_lap = 1'b1;
    give_ticks(10);
    pb_lap = 1'b0;
    expect_tr("short_back", S_LAP, S_RUN);
    chk("short_back_hold", 32'(lap_hold), 0);
    step(5);

    // LAP then START goes to PAUSE with lap_hold released
    pb_lap = 1'b1;
    step(4);
    pb_lap = 1'b0;
    step(D + 4);
    chk("lap_again", 32'(state_o), 32'(S_LAP));
    pb_start = 1'b1;
    expect_tr("lap_to_pause", S_LAP, S_PAUSE);
    chk("lap_to_pause_hold", 32'(lap_hold), 0);
    chk("lap_to_pause_en", 32'(count_en), 0);
    pb_start = 1'b0;
    step(D + 5);

    // Long LAP in PAUSE: reset to IDLE, then no more pulses
    pb_lap = 1'b1;
    step(5);
    pulse_cnt = 0;
    give_ticks(199);
    chk("pause_long_early", 32'(pulse_cnt), 0);
    chk("pause_long_wait", 32'(state_o), 32'(S_PAUSE));
    tick_100 = 1'b1;
    @(negedge clk);
    tick_100 = 1'b0;
    chk("pause_long_clear", 32'(clear), 1);
    chk("pause_long_pulse", 32'(long_press), 1);
    chk("pause_long_state", 32'(state_o), 32'(S_IDLE));
    @(negedge clk);
    chk("pause_long_clear_w", 32'(clear), 0);
    chk("pause_long_pulse_w", 32'(long_press), 0);
    pulse_cnt = 0;
    give_ticks(100);
    chk("pause_long_sat", 32'(pulse_cnt), 0);
    pb_lap = 1'b0;
    step(D + 5);
    chk("pause_long_rel", 32'(state_o), 32'(S_IDLE));

    // Long LAP in RUN: long_press only, release must not enter LAP
    press_start();
    chk("run2", 32'(state_o), 32'(S_RUN));
    pb_lap = 1'b1;
    step(5);
    give_ticks(199);
    tick_100 = 1'b1;
    @(negedge clk);
    tick_100 = 1'b0;
    chk("run_long_pulse", 32'(long_press), 1);
    chk("run_long_clear", 32'(clear), 0);
    chk("run_long_state", 32'(state_o), 32'(S_RUN));
    pb_lap = 1'b0;
    step(D + 5);
    chk("run_long_rel", 32'(state_o), 32'(S_RUN));
    chk("run_long_rel_hold", 32'(lap_hold), 0);

    // Simultaneous START and short LAP in RUN
    pb_lap = 1'b1;
    step(5);
    give_ticks(5);
    pb_lap   = 1'b0;
    pb_start = 1'b1;
    expect_tr("simul", S_RUN, S_PAUSE);
    chk("simul_hold", 32'(lap_hold), 0);
    step(5);
    chk("simul_dropped", 32'(state_o), 32'(S_PAUSE));
    pb_start = 1'b0;
    step(D + 5);

    // Reset mid-RUN with START held through release
    press_start();
    chk("pre_rst_en", 32'(count_en), 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_en", 32'(count_en), 0);
    chk("async_rst_state", 32'(state_o), 32'(S_IDLE));
    chk("async_rst_hold", 32'(lap_hold), 0);
    pb_start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    step(10);
    chk("held_no_ev", 32'(state_o), 32'(S_IDLE));
    pb_start = 1'b0;
    step(D + 5);
    chk("held_rel_no_ev", 32'(state_o), 32'(S_IDLE));
    pb_start = 1'b1;
    expect_tr("repress_run", S_IDLE, S_RUN);
    pb_start = 1'b0;
    step(3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
